ram_responder: RTL and testbench

Memory-side responder for the CPU data-RAM port. It holds the data store, answers the CPU's enable, write-enable and read-enable requests with registered read data, and decodes the top three addresses as memory-mapped I/O: a GPIO output register, a synchronized GPIO input and a free-running timer. It sits between the CPU and the board pins, at the opposite end of the CPU's RAM interface.

---
 rtl/ram_responder.sv | 104 ++++++++++
 tb/tb_ram_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// Data-RAM responder for the CPU port: word array plus three memory-mapped
// registers at the top of the address space (GPIO_OUT, GPIO_IN, TIMER).
module ram_responder #(
  parameter int unsigned g_RAM_WIDTH = 9,
  parameter int unsigned g_RAM_ADDR  = 11
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_ram_en,
  input  logic                   i_ram_we,
  input  logic                   i_ram_re,
  input  logic [g_RAM_ADDR-1:0]  i_ram_addr,
  input  logic [g_RAM_WIDTH-1:0] i_ram_data,
  output logic [g_RAM_WIDTH-1:0] o_ram_data,
  output logic                   o_ram_valid,
  input  logic [g_RAM_WIDTH-1:0] i_gpio,
  output logic [g_RAM_WIDTH-1:0] o_gpio
);

  localparam logic [g_RAM_ADDR-1:0] ADDR_GPIO_OUT = '1;
  localparam logic [g_RAM_ADDR-1:0] ADDR_GPIO_IN  = ADDR_GPIO_OUT - g_RAM_ADDR'(1);
  localparam logic [g_RAM_ADDR-1:0] ADDR_TIMER    = ADDR_GPIO_OUT - g_RAM_ADDR'(2);

  typedef enum logic [1:0] {
    REG_RAM,
    REG_GPIO_OUT,
    REG_GPIO_IN,
    REG_TIMER
  } region_e;

  logic [g_RAM_WIDTH-1:0] mem [2**g_RAM_ADDR];

  logic [g_RAM_WIDTH-1:0] rd_data_d, rd_data_q;
  logic                   rd_valid_d, rd_valid_q;
  logic [g_RAM_WIDTH-1:0] gpio_out_d, gpio_out_q;
  logic [g_RAM_WIDTH-1:0] timer_d, timer_q;
  logic [g_RAM_WIDTH-1:0] sync1_d, sync1_q;
  logic [g_RAM_WIDTH-1:0] sync2_d, sync2_q;

  region_e                region;
  logic                   wr_req;
  logic                   rd_req;
  logic                   ram_wr;
  logic [g_RAM_WIDTH-1:0] rd_mux;

  always_comb begin
    region = REG_RAM;
    if (i_ram_addr == ADDR_GPIO_OUT)     region = REG_GPIO_OUT;
    else if (i_ram_addr == ADDR_GPIO_IN) region = REG_GPIO_IN;
    else if (i_ram_addr == ADDR_TIMER)   region = REG_TIMER;
  end

  // All read sources are pre-edge values, which gives read-before-write for free.
  always_comb begin
    wr_req = i_ram_en && i_ram_we;
    rd_req = i_ram_en && i_ram_re;
    ram_wr = wr_req && (region == REG_RAM);

    rd_mux = '0;
    case (region)
      REG_RAM:      rd_mux = mem[i_ram_addr];
      REG_GPIO_OUT: rd_mux = gpio_out_q;
      REG_GPIO_IN:  rd_mux = sync2_q;
      REG_TIMER:    rd_mux = timer_q;
      default:      rd_mux = '0;
    endcase

    rd_data_d  = rd_req ? rd_mux : rd_data_q;
    rd_valid_d = rd_req;
    gpio_out_d = (wr_req && region == REG_GPIO_OUT) ? i_ram_data : gpio_out_q;
    timer_d    = (wr_req && region == REG_TIMER) ? i_ram_data
                                                  : timer_q + g_RAM_WIDTH'(1);
    sync1_d    = i_gpio;
    sync2_d    = sync1_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      gpio_out_q <= '0;
      timer_q    <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      gpio_out_q <= gpio_out_d;
      timer_q    <= timer_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
    end
  end

  // Array contents are deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (ram_wr) mem[i_ram_addr] <= i_ram_data;
  end

  assign o_ram_data  = rd_data_q;
  assign o_ram_valid = rd_valid_q;
  assign o_gpio      = gpio_out_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: reads push expected data with a due cycle,
// and a negedge monitor checks every cycle for the expected read or no valid.
module tb_ram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, we, re;
  logic [10:0] addr;
  logic [8:0]  wdata;
  logic [8:0]  rdata;
  logic        rvalid;
  logic [8:0]  gpio_in;
  logic [8:0]  gpio_out;

  localparam logic [10:0] A_GPIO_OUT = 11'h7FF;
  localparam logic [10:0] A_GPIO_IN  = 11'h7FE;
  localparam logic [10:0] A_TIMER    = 11'h7FD;

  typedef struct {
    logic [8:0] data;
    int         due;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  ram_responder #(.g_RAM_WIDTH(9), .g_RAM_ADDR(11)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_ram_en   (en),
    .i_ram_we   (we),
    .i_ram_re   (re),
    .i_ram_addr (addr),
    .i_ram_data (wdata),
    .o_ram_data (rdata),
    .o_ram_valid(rvalid),
    .i_gpio     (gpio_in),
    .o_gpio     (gpio_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("rd_valid", {8'h0, rvalid}, 9'h001);
      chk("rd_data", rdata, e.data);
    end else begin
      chk("no_valid", {8'h0, rvalid}, 9'h000);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic den, input logic dwe, input logic dre,
                       input logic [10:0] da, input logic [8:0] dd);
    en = den; we = dwe; re = dre; addr = da; wdata = dd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 11'h000, 9'h000);
  endtask

  task automatic wr(input logic [10:0] a, input logic [8:0] d);
    drive(1'b1, 1'b1, 1'b0, a, d);
    step();
  endtask

  task automatic rd(input logic [10:0] a, input logic [8:0] exp);
    drive(1'b1, 1'b0, 1'b1, a, 9'h000);
    q.push_back('{data: exp, due: cyc + 1});
    step();
  endtask

  task automatic rdwr(input logic [10:0] a, input logic [8:0] d, input logic [8:0] exp);
    drive(1'b1, 1'b1, 1'b1, a, d);
    q.push_back('{data: exp, due: cyc + 1});
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    gpio_in = 9'h000;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", rdata, 9'h000);
    chk("rst_valid", {8'h0, rvalid}, 9'h000);
    chk("rst_gpio", gpio_out, 9'h000);
    rst_n = 1'b1;
    chk("rel_data", rdata, 9'h000);
    chk("rel_gpio", gpio_out, 9'h000);
    repeat (4) step();
    rd(A_TIMER, 9'h004);
    idle(); step();

    wr(11'h010, 9'h1A5);
    rd(11'h010, 9'h1A5);
    wr(11'h011, 9'h0F0);
    rd(11'h010, 9'h1A5);
    rd(11'h011, 9'h0F0);
    idle(); step();

    wr(11'h020, 9'h055);
    rdwr(11'h020, 9'h0AA, 9'h055);
    rd(11'h020, 9'h0AA);
    drive(1'b0, 1'b1, 1'b0, 11'h020, 9'h111);
    step();
    rd(11'h020, 9'h0AA);
    idle(); step();

    wr(A_GPIO_OUT, 9'h1FF);
    chk("gpio_out", gpio_out, 9'h1FF);
    rd(A_GPIO_OUT, 9'h1FF);
    gpio_in = 9'h0C3;
    wr(A_GPIO_IN, 9'h123);
    rd(A_GPIO_IN, 9'h000);
    rd(A_GPIO_IN, 9'h0C3);
    chk("gpio_out_kept", gpio_out, 9'h1FF);

    wr(A_TIMER, 9'h1FE);
    rd(A_TIMER, 9'h1FE);
    rd(A_TIMER, 9'h1FF);
    rd(A_TIMER, 9'h000);
    rdwr(A_TIMER, 9'h050, 9'h001);
    rd(A_TIMER, 9'h050);
    idle(); step();

    wr(11'h030, 9'h15A);
    drive(1'b1, 1'b0, 1'b1, 11'h030, 9'h000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_data", rdata, 9'h000);
    chk("midrst_valid", {8'h0, rvalid}, 9'h000);
    idle();
    step();
    step();
    chk("midrst_data2", rdata, 9'h000);
    chk("midrst_gpio", gpio_out, 9'h000);
    rst_n = 1'b1;
    step();
    rd(11'h030, 9'h15A);
    rd(11'h010, 9'h1A5);
    idle();
    repeat (3) step();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending reads expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
